regfile_wb_arbiter: RTL

//  Write-back controller for the 16x16 register file. ALU results and memory load returns both

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU results vs. load returns share one write port,
// with a load scoreboard that flags decode-stage RAW hazards and protocol errors.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [3:0]        alu_rdest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [3:0]        mem_rdest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              ld_issue,
    input  logic [3:0]        ld_issue_rdest,
    input  logic [3:0]        rsrc_a,
    input  logic [3:0]        rsrc_b,
    output logic              hazard,
    output logic              reg_Wen,
    output logic [3:0]        reg_en,
    output logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   pending,
    output logic              sb_err
);

    typedef enum logic {GrantAlu, GrantMem} grant_e;

    grant_e            last_grant_q;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              sb_err_q, sb_err_d;
    logic              wen_q;
    logic [3:0]        reg_en_q;
    logic [DATA_W-1:0] wb_data_q;

    logic alu_elig, mem_elig, conflict, grant_alu, grant_mem;

    // ALU is held off while a load to the same destination is outstanding (WAW).
    always_comb begin
        alu_elig  = alu_valid && !pending_q[alu_rdest];
        mem_elig  = mem_valid;
        conflict  = alu_elig && mem_elig;
        grant_mem = !reset && mem_elig && (!alu_elig || (last_grant_q == GrantAlu));
        grant_alu = !reset && alu_elig && !grant_mem;
    end

    always_comb begin
        pending_d = pending_q;
        sb_err_d  = sb_err_q;
        if (grant_mem) begin
            pending_d[mem_rdest] = 1'b0;
            if (!pending_q[mem_rdest]) begin
                sb_err_d = 1'b1;
            end
        end
        // A reissue onto a register whose load lands this same cycle is a fresh load, not an error.
        if (ld_issue) begin
            pending_d[ld_issue_rdest] = 1'b1;
            if (pending_q[ld_issue_rdest] && !(grant_mem && (mem_rdest == ld_issue_rdest))) begin
                sb_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GrantAlu;
            pending_q    <= '0;
            sb_err_q     <= 1'b0;
            wen_q        <= 1'b0;
            reg_en_q     <= '0;
            wb_data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            sb_err_q  <= sb_err_d;
            wen_q     <= grant_alu || grant_mem;
            if (conflict) begin
                last_grant_q <= grant_mem ? GrantMem : GrantAlu;
            end
            if (grant_mem) begin
                reg_en_q  <= mem_rdest;
                wb_data_q <= mem_data;
            end else if (grant_alu) begin
                reg_en_q  <= alu_rdest;
                wb_data_q <= alu_data;
            end
        end
    end

    always_comb begin
        alu_ready = grant_alu;
        mem_ready = grant_mem;
        hazard    = pending_q[rsrc_a] | pending_q[rsrc_b];
        reg_Wen   = wen_q;
        reg_en    = reg_en_q;
        wb_data   = wb_data_q;
        pending   = pending_q;
        sb_err    = sb_err_q;
    end

endmodule
